// File: rtl/rob_pkg.sv
// Shared sizing and entry layout for the reorder buffer and its pointers.
package rob_pkg;

   localparam int unsigned ROB   = 2;
   localparam int unsigned REG   = 4;
   localparam int unsigned WIDTH = 31;
   localparam int unsigned IDX_W = ROB + 1;
   localparam int unsigned CNT_W = ROB + 2;
   localparam int unsigned DEPTH = 2 ** (ROB + 1);

   typedef logic [ROB:0] robIdx_t;

   typedef struct packed {
      logic             valid;
      logic             ready;
      logic             mispredict;
      logic             regWrite;
      logic [REG:0]     destReg;
      logic [WIDTH:0]   result;
      logic [WIDTH:0]   snap;
   } robEntry_t;

endpackage

// File: rtl/rob_pointer.sv
// Wrap-around entry pointer with increment and synchronous clear (flush).
module rob_pointer
   import rob_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    inc,
   input  logic    clr,
   output robIdx_t ptr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + IDX_W'(1);
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, CDB writeback, retire from head,
// flush on a retiring mispredict.
module reorder_buffer
   import rob_pkg::*;
(
   input  logic             clk,
   input  logic             globalReset,
   input  logic             allocate,
   input  logic             regWrite,
   input  logic [REG:0]     destRegR,
   input  logic [WIDTH:0]   regStatusSnap,
   input  logic             cdbValid,
   input  logic [ROB:0]     cdbROB,
   input  logic [WIDTH:0]   cdbResult,
   input  logic             cdbMispredict,
   output logic [ROB:0]     destROB,
   output logic             robFull,
   output logic             validCommit,
   output logic [ROB:0]     commitROB,
   output logic [REG:0]     regCommit,
   output logic             commitWe,
   output logic [WIDTH:0]   commitResult,
   output logic             reset,
   output logic [WIDTH:0]   statusRestore
);

   robEntry_t        entries [DEPTH];
   robEntry_t        head_e;
   robIdx_t          head;
   robIdx_t          tail;
   logic [CNT_W-1:0] count;
   logic             commit_fire;
   logic             flush;
   logic             alloc_fire;
   logic             wb_fire;

   rob_pointer u_head (
      .clk (clk),
      .rst (globalReset),
      .inc (commit_fire),
      .clr (flush),
      .ptr (head)
   );

   rob_pointer u_tail (
      .clk (clk),
      .rst (globalReset),
      .inc (alloc_fire),
      .clr (flush),
      .ptr (tail)
   );

   assign head_e = entries[head];

   // A retiring mispredict squashes any same-cycle allocation and writeback.
   always_comb begin
      commit_fire = head_e.valid & head_e.ready;
      flush       = commit_fire & head_e.mispredict;
      alloc_fire  = allocate & ~robFull & ~flush;
      wb_fire     = cdbValid & entries[cdbROB].valid & ~flush;
   end

   assign robFull       = (count == CNT_W'(DEPTH));
   assign destROB       = tail;
   assign validCommit   = commit_fire;
   assign commitROB     = head;
   assign regCommit     = commit_fire ? head_e.destReg : '0;
   assign commitWe      = commit_fire & head_e.regWrite;
   assign commitResult  = head_e.result;
   assign reset         = flush;
   assign statusRestore = head_e.snap;

   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (alloc_fire && !commit_fire) begin
         count <= count + CNT_W'(1);
      end else if (commit_fire && !alloc_fire) begin
         count <= count - CNT_W'(1);
      end
   end

   // Full buffer means tail never aliases a retiring head, so update order is safe.
   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) begin
         entries <= '{default: '0};
      end else if (flush) begin
         entries <= '{default: '0};
      end else begin
         if (wb_fire) begin
            entries[cdbROB].ready      <= 1'b1;
            entries[cdbROB].result     <= cdbResult;
            entries[cdbROB].mispredict <= cdbMispredict;
         end
         if (commit_fire) begin
            entries[head] <= '0;
         end
         if (alloc_fire) begin
            entries[tail] <= '{valid: 1'b1, ready: 1'b0, mispredict: 1'b0,
                               regWrite: regWrite, destReg: destRegR,
                               result: '0, snap: regStatusSnap};
         end
      end
   end

endmodule
